// File: rtl/dac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Purpose  : Frame layout, command/address codes and FSM state type shared by
//            the quad-DAC SPI receiver.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int FRAME_BITS = 32;
    localparam int DATA_BITS  = 12;
    localparam int NUM_CH     = 4;

    localparam int CMD_MSB    = 23;
    localparam int CMD_LSB    = 20;
    localparam int ADDR_MSB   = 19;
    localparam int ADDR_LSB   = 16;
    localparam int DATA_MSB   = 15;
    localparam int DATA_LSB   = 4;

    localparam logic [3:0] CMD_WRITE_IN     = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
    localparam logic [3:0] CMD_NOP          = 4'b1111;

    localparam logic [3:0] ADDR_A   = 4'b0000;
    localparam logic [3:0] ADDR_B   = 4'b0001;
    localparam logic [3:0] ADDR_C   = 4'b0010;
    localparam logic [3:0] ADDR_D   = 4'b0011;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    function automatic logic cmd_legal(input logic [3:0] cmd);
        case (cmd)
            CMD_WRITE_IN, CMD_UPDATE, CMD_WRITE_UPDATE,
            CMD_POWER_DOWN, CMD_NOP: cmd_legal = 1'b1;
            default:                 cmd_legal = 1'b0;
        endcase
    endfunction

    // One-hot channel select; all-zero marks an illegal address.
    function automatic logic [3:0] addr_mask(input logic [3:0] addr);
        case (addr)
            ADDR_A:   addr_mask = 4'b0001;
            ADDR_B:   addr_mask = 4'b0010;
            ADDR_C:   addr_mask = 4'b0100;
            ADDR_D:   addr_mask = 4'b1000;
            ADDR_ALL: addr_mask = 4'b1111;
            default:  addr_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_sync
// Purpose  : Multi-flop synchronizer followed by a registered edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;

    // Level and edge pulses are registered together so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= {STAGES{IDLE_LEVEL}};
            r_level <= IDLE_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[STAGES-2:0], i_din};
            r_level <= r_sync[STAGES-1];
            r_rise  <= r_sync[STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/dac_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dac_spi_rx
// Purpose  : SPI slave for a quad 12-bit DAC: frame capture, command decode,
//            per-channel input/DAC registers, power-down flags and MISO echo.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_rx
    import dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dac_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        dac_clr,
    output logic        spi_miso,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_c,
    output logic [11:0] dac_d,
    output logic [3:0]  pd,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  last_cmd,
    output logic [3:0]  last_addr
);

    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_sck_level, w_sck_rise, w_sck_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_clr_n, w_clr_rise, w_clr_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .i_din(dac_cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .i_din(spi_sck),
        .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .i_din(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_clr (
        .clk(clk), .reset(reset), .i_din(dac_clr),
        .o_level(w_clr_n), .o_rise(w_clr_rise), .o_fall(w_clr_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_cs_level, w_sck_level, w_mosi_rise, w_mosi_fall,
                        w_clr_rise, w_clr_fall};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  r_echo;
    logic [FRAME_BITS-1:0]  r_miso_sh;
    logic [5:0]             r_count;
    logic                   r_frame_valid;
    logic                   r_frame_err;
    logic [3:0]             r_last_cmd;
    logic [3:0]             r_last_addr;

    logic [3:0]             w_cmd;
    logic [3:0]             w_addr;
    logic [DATA_BITS-1:0]   w_data;
    logic [NUM_CH-1:0]      w_mask;
    logic                   w_accept;
    logic                   w_decode;
    logic                   w_apply;

    assign w_cmd    = r_shift[CMD_MSB:CMD_LSB];
    assign w_addr   = r_shift[ADDR_MSB:ADDR_LSB];
    assign w_data   = r_shift[DATA_MSB:DATA_LSB];
    assign w_mask   = addr_mask(w_addr);
    assign w_accept = (r_count == 6'(FRAME_BITS)) && cmd_legal(w_cmd) && (w_mask != 4'b0000);
    // A clear during DECODE wins: the frame is dropped without any pulse.
    assign w_decode = (r_state == ST_DECODE) && w_clr_n;
    assign w_apply  = w_decode && w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (w_cs_rise) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (!w_clr_n) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_echo        <= '0;
            r_miso_sh     <= '0;
            r_count       <= 6'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_last_cmd    <= 4'd0;
            r_last_addr   <= 4'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_clr_n) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_shift   <= '0;
                            r_count   <= 6'd0;
                            r_miso_sh <= r_echo;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_sck_rise) begin
                            r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi};
                            r_count <= (r_count == 6'd63) ? r_count : r_count + 6'd1;
                        end
                        if (w_sck_fall)
                            r_miso_sh <= {r_miso_sh[FRAME_BITS-2:0], 1'b0};
                    end
                    ST_DECODE: begin
                        if (w_accept) begin
                            r_frame_valid <= 1'b1;
                            r_last_cmd    <= w_cmd;
                            r_last_addr   <= w_addr;
                            r_echo        <= r_shift;
                        end else begin
                            r_frame_err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] w_dac [NUM_CH];
    logic [NUM_CH-1:0]    w_pd;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic [DATA_BITS-1:0] r_in_reg;
        logic [DATA_BITS-1:0] r_dac_reg;
        logic                 r_pd;

        always_ff @(posedge clk or posedge reset) begin
            if (reset || !w_clr_n) begin
                r_in_reg  <= '0;
                r_dac_reg <= '0;
                r_pd      <= 1'b0;
            end else if (w_apply && w_mask[i]) begin
                case (w_cmd)
                    CMD_WRITE_IN: r_in_reg <= w_data;
                    CMD_UPDATE: begin
                        r_dac_reg <= r_in_reg;
                        r_pd      <= 1'b0;
                    end
                    CMD_WRITE_UPDATE: begin
                        r_in_reg  <= w_data;
                        r_dac_reg <= w_data;
                        r_pd      <= 1'b0;
                    end
                    CMD_POWER_DOWN: r_pd <= 1'b1;
                    default: ;
                endcase
            end
        end

        assign w_dac[i] = r_dac_reg;
        assign w_pd[i]  = r_pd;
    end

    assign dac_a       = w_dac[0];
    assign dac_b       = w_dac[1];
    assign dac_c       = w_dac[2];
    assign dac_d       = w_dac[3];
    assign pd          = w_pd;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign last_cmd    = r_last_cmd;
    assign last_addr   = r_last_addr;
    assign spi_miso    = (r_state == ST_SHIFT) ? r_miso_sh[FRAME_BITS-1] : 1'b0;

endmodule
`default_nettype wire

// File: doc/dac_spi_rx.md
DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on each SPI input; legal range 2..3.
REQ-002 clk  input  1  50 MHz system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dac_cs  input  1  SPI chip select, active low; frame boundary.
REQ-005 spi_sck  input  1  SPI serial clock from master.
REQ-006 spi_mosi  input  1  serial data from master, MSB first.
REQ-007 dac_clr  input  1  active-low clear of all channel registers.
REQ-008 spi_miso  output  1  echo of previous accepted frame, MSB first.
REQ-009 dac_a, dac_b, dac_c, dac_d  output  12 each  active DAC register value per channel.
REQ-010 pd  output  4  per-channel power-down flag, bit0 = A.
REQ-011 frame_valid  output  1  one-cycle pulse: 32-bit frame accepted and applied.
REQ-012 frame_err  output  1  one-cycle pulse: frame discarded.
REQ-013 last_cmd, last_addr  output  4 each  fields of the last accepted frame.

Function
REQ-014 dac_cs, spi_sck, spi_mosi and dac_clr SHALL pass through SYNC_STAGES flops plus one edge-detect flop; all decisions use the synchronized copies.
REQ-015 SCK high and low phases SHALL each be at least 1 clk period; MOSI is sampled on the detected SCK rising edge.
REQ-016 FSM states: IDLE (cs high), SHIFT (cs low), DECODE (one cycle); IDLE->SHIFT on cs fall; SHIFT->DECODE on cs rise; DECODE->IDLE unconditionally.
REQ-017 SHIFT SHALL shift sampled bits into a 32-bit register and increment a 6-bit bit counter that saturates at 63.
REQ-018 Frame layout: [31:24] ignored, [23:20] command, [19:16] address, [15:4] data, [3:0] ignored.
REQ-019 DECODE with count != 32 SHALL pulse frame_err and leave all registers unchanged.
REQ-020 Commands: 0000 write input reg; 0001 copy input reg to DAC reg and clear pd; 0011 write input and DAC reg and clear pd; 0100 set pd; 1111 no-op (frame_valid only).
REQ-021 Any other command SHALL pulse frame_err with no register change.
REQ-022 Address 0000..0011 selects A..D; 1111 selects all four; any other address SHALL pulse frame_err.
REQ-023 Accepted frames SHALL update registers, last_cmd, last_addr and the echo register, and pulse frame_valid, all on the same clk edge.
REQ-024 frame_valid/frame_err latency: asserted on the (SYNC_STAGES+2)th rising clk edge after the first edge that samples dac_cs high; exactly 1 cycle wide.
REQ-025 On detected cs fall, the echo register SHALL load into a MISO shifter; spi_miso drives bit 31 immediately and advances one bit per detected SCK falling edge.
REQ-026 spi_miso SHALL be 0 in IDLE.
REQ-027 Synchronized dac_clr low SHALL zero all input and DAC registers and pd in every state.
REQ-028 Synchronized dac_clr low SHALL abort an in-progress frame to IDLE with no pulse.
REQ-029 dac_clr low SHALL take precedence over a simultaneous DECODE.
REQ-030 A cs rise with zero SCK edges SHALL yield frame_err.

Reset
REQ-031 reset SHALL force: FSM IDLE; counter 0; shift, echo and all channel registers 0; pd 4'b0000; outputs 0 (spi_miso 0, frame_valid 0, frame_err 0, last_cmd/last_addr 0); synchronizer flops to their idle levels (cs 1, sck 0, mosi 0, clr 1).
REQ-032 reset asserted mid-frame SHALL discard the frame; after release, no frame is accepted until a fresh cs fall.

Structure
REQ-033 Package dac_pkg SHALL hold FRAME_BITS=32, field bit positions, command codes, address codes and the FSM state type.
REQ-034 Sub-module spi_sync SHALL implement one synchronizer-plus-edge-detect, instantiated once per input, with rise and fall outputs.

Verification
REQ-035 Frame cmd 0011, addr 0000, data 0xB00 -> dac_a=0xB00, pd[0]=0, frame_valid one pulse at the REQ-024 latency, other channels 0.
REQ-036 cmd 0000 addr 0001 data 0x123 -> dac_b stays 0; then cmd 0001 addr 0001 -> dac_b=0x123.
REQ-037 cmd 0011 addr 1111 data 0xFFF -> all four channels 0xFFF; next frame's spi_miso bits equal the previous frame word.
REQ-038 31-bit frame and 33-bit frame -> frame_err each, no register change.
REQ-039 dac_clr low at bit 16 of a frame -> all channels 0, no frame_valid; next full frame is accepted normally.
REQ-040 reset pulse at bit 10 -> all outputs at reset values; following complete frame is accepted.
